// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the bit-serial ALU: FSM states, mode/selector encodings
// and the counter-width helper.
package alu_serial_pkg;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      CALCULO = 2'd1,
      FIN     = 2'd2
   } estado_t;

   localparam logic MODO_LOGICO     = 1'b0;
   localparam logic MODO_ARITMETICO = 1'b1;

   // Arithmetic: 00 A-1+Cin, 01 A+B+Cin, 10 A+~B+Cin, 11 A+Cin
   // Logic:      00 AND,     01 OR,      10 XOR,      11 NOT A
   localparam logic [1:0] SEL_00 = 2'b00;
   localparam logic [1:0] SEL_01 = 2'b01;
   localparam logic [1:0] SEL_10 = 2'b10;
   localparam logic [1:0] SEL_11 = 2'b11;

   localparam logic [1:0] OP_AND   = SEL_00;
   localparam logic [1:0] OP_OR    = SEL_01;
   localparam logic [1:0] OP_XOR   = SEL_10;
   localparam logic [1:0] OP_NOT_A = SEL_11;

   function automatic int clog2(input int valor);
      int r;
      r = 0;
      while ((1 << r) < valor) r++;
      return r;
   endfunction

endpackage

// File: rtl/celda_alu_bit.sv
// One bit slice of the serial ALU: extended-B generation, full adder and logic mux.
module celda_alu_bit
   import alu_serial_pkg::*;
(
   input  logic       bitA,
   input  logic       bitB,
   input  logic       acarreoEnt,
   input  logic       modo,
   input  logic [1:0] selector,
   output logic       bitR,
   output logic       acarreoSal
);

   logic bitY;

   always_comb begin
      bitY       = (~bitB & modo & ~selector[0]) | (bitB & modo & ~selector[1]);
      bitR       = 1'b0;
      acarreoSal = 1'b0;
      if (modo == MODO_LOGICO) begin
         case (selector)
            OP_AND:  bitR = bitA & bitB;
            OP_OR:   bitR = bitA | bitB;
            OP_XOR:  bitR = bitA ^ bitB;
            OP_NOT_A: bitR = ~bitA;
            default: bitR = 1'b0;
         endcase
      end else begin
         bitR       = bitA ^ bitY ^ acarreoEnt;
         acarreoSal = (bitA & bitY) | (bitA & acarreoEnt) | (bitY & acarreoEnt);
      end
   end

endmodule

// File: rtl/alu_serial_secuencial.sv
// Bit-serial ALU, LSB first, one bit per clock. Optional BANDERAS_EN adds the
// registered Cero/Desborde flags alongside Resultado.
module alu_serial_secuencial
   import alu_serial_pkg::*;
#(
   parameter int ANCHO = 8
) (
   input  logic             Reloj,
   input  logic             ResetN,
   input  logic             Inicio,
   input  logic [ANCHO-1:0] OperandoA,
   input  logic [ANCHO-1:0] OperandoB,
   input  logic             ControlModo,
   input  logic [1:0]       SelectorOperacion,
   input  logic             AcarreoEntrada,
   output logic             Listo,
   output logic             Valido,
   output logic [ANCHO-1:0] Resultado,
   output logic             AcarreoSalida
`ifdef BANDERAS_EN
   ,
   output logic             Cero,
   output logic             Desborde
`endif
);

   localparam int ANCHO_CONT = clog2(ANCHO);
   localparam logic [ANCHO_CONT-1:0] ULTIMO_BIT = ANCHO_CONT'(ANCHO - 1);

   estado_t                estado, estadoSig;
   logic [ANCHO-1:0]       despA, despB, despRes, resultadoFinal;
   logic                   modo, acarreo, bitRes, acarreoSig, acepta;
   logic [1:0]             selector;
   logic [ANCHO_CONT-1:0]  contador;

   celda_alu_bit uCelda (
      .bitA       (despA[0]),
      .bitB       (despB[0]),
      .acarreoEnt (acarreo),
      .modo       (modo),
      .selector   (selector),
      .bitR       (bitRes),
      .acarreoSal (acarreoSig)
   );

   // Bits enter at the MSB so the first (LSB) bit lands at position 0 after ANCHO shifts.
   assign resultadoFinal = {bitRes, despRes[ANCHO-1:1]};

   always_ff @(posedge Reloj) begin
      if (!ResetN) estado <= REPOSO;
      else         estado <= estadoSig;
   end

   always_comb begin
      estadoSig = estado;
      Listo     = 1'b0;
      Valido    = 1'b0;
      acepta    = 1'b0;
      case (estado)
         REPOSO: begin
            Listo = 1'b1;
            if (Inicio) begin
               acepta    = 1'b1;
               estadoSig = CALCULO;
            end
         end
         CALCULO: if (contador == ULTIMO_BIT) estadoSig = FIN;
         FIN: begin
            Valido    = 1'b1;
            estadoSig = REPOSO;
         end
         default: estadoSig = REPOSO;
      endcase
   end

   always_ff @(posedge Reloj) begin
      if (!ResetN) begin
         despA         <= '0;
         despB         <= '0;
         despRes       <= '0;
         modo          <= 1'b0;
         selector      <= 2'b00;
         acarreo       <= 1'b0;
         contador      <= '0;
         Resultado     <= '0;
         AcarreoSalida <= 1'b0;
`ifdef BANDERAS_EN
         Cero          <= 1'b0;
         Desborde      <= 1'b0;
`endif
      end else if (acepta) begin
         despA    <= OperandoA;
         despB    <= OperandoB;
         despRes  <= '0;
         modo     <= ControlModo;
         selector <= SelectorOperacion;
         acarreo  <= (ControlModo == MODO_ARITMETICO) & AcarreoEntrada;
         contador <= '0;
      end else if (estado == CALCULO) begin
         despA    <= despA >> 1;
         despB    <= despB >> 1;
         despRes  <= resultadoFinal;
         acarreo  <= acarreoSig;
         contador <= contador + 1'b1;
         if (contador == ULTIMO_BIT) begin
            Resultado     <= resultadoFinal;
            AcarreoSalida <= acarreoSig;
`ifdef BANDERAS_EN
            Cero          <= (resultadoFinal == '0);
            // acarreo holds the carry into the MSB while the MSB is processed
            Desborde      <= (modo == MODO_ARITMETICO) & (acarreo ^ acarreoSig);
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_serial_secuencial.sv
// Scoreboard bench for alu_serial_secuencial (ANCHO=8); flag checks active with BANDERAS_EN.
module tb_alu_serial_secuencial;

   localparam int ANCHO = 8;

   logic             Reloj = 1'b0;
   logic             ResetN = 1'b0;
   logic             Inicio = 1'b0;
   logic [ANCHO-1:0] OperandoA = '0;
   logic [ANCHO-1:0] OperandoB = '0;
   logic             ControlModo = 1'b0;
   logic [1:0]       SelectorOperacion = 2'b00;
   logic             AcarreoEntrada = 1'b0;
   logic             Listo, Valido, AcarreoSalida;
   logic [ANCHO-1:0] Resultado;
`ifdef BANDERAS_EN
   logic             Cero, Desborde;
`endif

   alu_serial_secuencial #(.ANCHO(ANCHO)) dut (
      .Reloj             (Reloj),
      .ResetN            (ResetN),
      .Inicio            (Inicio),
      .OperandoA         (OperandoA),
      .OperandoB         (OperandoB),
      .ControlModo       (ControlModo),
      .SelectorOperacion (SelectorOperacion),
      .AcarreoEntrada    (AcarreoEntrada),
      .Listo             (Listo),
      .Valido            (Valido),
      .Resultado         (Resultado),
      .AcarreoSalida     (AcarreoSalida)
`ifdef BANDERAS_EN
      ,
      .Cero              (Cero),
      .Desborde          (Desborde)
`endif
   );

   always #5 Reloj = ~Reloj;

   typedef struct {
      logic [ANCHO-1:0] res;
      logic             c;
      logic             z;
      logic             v;
      int               ciclo;
   } esperado_t;

   esperado_t cola[$];
   esperado_t eMon;
   int ciclo = 0;
   int nComp = 0;
   int nErr  = 0;

   always @(posedge Reloj) ciclo <= ciclo + 1;

   task automatic comprobar(input string nombre, input logic [31:0] actual, input logic [31:0] req);
      nComp++;
      if (actual !== req) begin
         nErr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nombre, actual, req, $time);
      end
   endtask

   // Monitor: every Valido pops one expected response
   always @(negedge Reloj) begin
      if (ResetN && Valido) begin
         if (cola.size() == 0) begin
            comprobar("unexpected_valido", 32'd1, 32'd0);
         end else begin
            eMon = cola.pop_front();
            comprobar("resultado", 32'(Resultado), 32'(eMon.res));
            comprobar("acarreo_salida", 32'(AcarreoSalida), 32'(eMon.c));
            comprobar("latencia", 32'(ciclo), 32'(eMon.ciclo));
`ifdef BANDERAS_EN
            comprobar("cero", 32'(Cero), 32'(eMon.z));
            comprobar("desborde", 32'(Desborde), 32'(eMon.v));
`endif
         end
      end
   end

   task automatic esperarListo();
      int t;
      t = 0;
      @(negedge Reloj);
      while (!Listo && t < 50) begin
         @(negedge Reloj);
         t++;
      end
      if (!Listo) comprobar("timeout_listo", 32'(Listo), 32'd1);
   endtask

   task automatic ejecutar(input logic m, input logic [1:0] s, input logic [ANCHO-1:0] a,
                           input logic [ANCHO-1:0] b, input logic cin, input logic [ANCHO-1:0] res,
                           input logic c, input logic z, input logic v);
      esperado_t e;
      esperarListo();
      OperandoA = a; OperandoB = b; ControlModo = m;
      SelectorOperacion = s; AcarreoEntrada = cin; Inicio = 1'b1;
      @(posedge Reloj);
      #1;
      e.res = res; e.c = c; e.z = z; e.v = v; e.ciclo = ciclo + ANCHO;
      cola.push_back(e);
      Inicio = 1'b0;
      // Scrambled inputs after accept must not disturb the run
      OperandoA = ~a; OperandoB = a ^ b; ControlModo = ~m;
      SelectorOperacion = ~s; AcarreoEntrada = ~cin;
      @(negedge Reloj);
      comprobar("listo_ocupado", 32'(Listo), 32'd0);
   endtask

   initial begin
      esperado_t e;
      int t;
      repeat (2) @(posedge Reloj);
      #1;
      comprobar("reset_listo", 32'(Listo), 32'd1);
      comprobar("reset_valido", 32'(Valido), 32'd0);
      comprobar("reset_resultado", 32'(Resultado), 32'd0);
      comprobar("reset_acarreo", 32'(AcarreoSalida), 32'd0);
      ResetN = 1'b1;

      //        M     S      A      B      Cin   Res    C     Z     V
      ejecutar(1'b1, 2'b01, 8'h3C, 8'h19, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      ejecutar(1'b1, 2'b10, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
      ejecutar(1'b1, 2'b10, 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
      ejecutar(1'b1, 2'b00, 8'h00, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
      ejecutar(1'b0, 2'b10, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0);
      ejecutar(1'b0, 2'b00, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
      ejecutar(1'b0, 2'b01, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0);
      ejecutar(1'b0, 2'b11, 8'hF0, 8'h3C, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
      ejecutar(1'b0, 2'b00, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      ejecutar(1'b1, 2'b11, 8'hFF, 8'h77, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
      ejecutar(1'b1, 2'b01, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
      ejecutar(1'b1, 2'b00, 8'h05, 8'h00, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0);

      // Inicio held high through the whole run while operands keep changing
      esperarListo();
      comprobar("resultado_retenido", 32'(Resultado), 32'h05);
      OperandoA = 8'h12; OperandoB = 8'h34; ControlModo = 1'b1;
      SelectorOperacion = 2'b01; AcarreoEntrada = 1'b0; Inicio = 1'b1;
      @(posedge Reloj);
      #1;
      e.res = 8'h46; e.c = 1'b0; e.z = 1'b0; e.v = 1'b0; e.ciclo = ciclo + ANCHO;
      cola.push_back(e);
      t = 0;
      do begin
         @(negedge Reloj);
         OperandoA = 8'(t * 37); OperandoB = ~OperandoA; ControlModo = t[0];
         if (!Valido) comprobar("listo_en_calculo", 32'(Listo), 32'd0);
         if (t == 3) comprobar("resultado_estable_calculo", 32'(Resultado), 32'h05);
         t++;
      end while (!Valido && t < 20);
      if (!Valido) comprobar("timeout_valido", 32'(Valido), 32'd1);
      Inicio = 1'b0;
      repeat (3) begin
         @(negedge Reloj);
         comprobar("sin_reaceptar", 32'(Listo), 32'd1);
      end

      // Reset while bit 4 is being processed aborts the run
      esperarListo();
      OperandoA = 8'h3C; OperandoB = 8'h19; ControlModo = 1'b1;
      SelectorOperacion = 2'b01; AcarreoEntrada = 1'b0; Inicio = 1'b1;
      @(posedge Reloj);
      #1;
      Inicio = 1'b0;
      repeat (4) @(posedge Reloj);
      @(negedge Reloj);
      ResetN = 1'b0;
      @(posedge Reloj);
      #1;
      ResetN = 1'b1;
      comprobar("abort_listo", 32'(Listo), 32'd1);
      comprobar("abort_resultado", 32'(Resultado), 32'd0);
      comprobar("abort_acarreo", 32'(AcarreoSalida), 32'd0);
      repeat (12) @(posedge Reloj);
      ejecutar(1'b1, 2'b01, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

      // Signed overflow corners
      ejecutar(1'b1, 2'b01, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      ejecutar(1'b1, 2'b01, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);

      t = 0;
      while (cola.size() != 0 && t < 50) begin
         @(negedge Reloj);
         t++;
      end
      if (cola.size() != 0) comprobar("timeout_pendientes", 32'(cola.size()), 32'd0);
      repeat (2) @(negedge Reloj);

      $display("== %0d vectors applied, %0d miscompares ==", nComp, nErr);
      $finish;
   end

endmodule
